// File: rtl/data_memory.sv
// Doubleword-indexed data memory with a post-reset clear engine and a sticky fault flag.
// Optional load/store counters are compiled in with DMEM_STATS_EN.
module data_memory #(
    parameter int          DEPTH    = 256,
    parameter int          AW       = 8,
    parameter logic [63:0] INIT_VAL = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] memAddr,
    input  logic [63:0] memWriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [63:0] memReadData,
    output logic        ready,
    output logic        fault,
`ifdef DMEM_STATS_EN
    output logic [31:0] rd_count,
    output logic [31:0] wr_count,
`endif
    output logic [63:0] fault_addr
);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [AW-1:0] init_ptr_q, init_ptr_d;
    logic        fault_q, fault_d;
    logic [63:0] fault_addr_q, fault_addr_d;

    logic [63:0] mem [DEPTH];

    logic          in_range;
    logic [AW-1:0] idx;
    logic          run;
    logic          do_rd, do_wr, bad_acc;
    logic          we;
    logic [AW-1:0] waddr;
    logic [63:0]   wdata;

    assign in_range = (memAddr[63:AW] == '0);
    assign idx      = memAddr[AW-1:0];
    assign run      = (state_q == S_RUN);
    assign do_rd    = run && MemRead && in_range;
    assign do_wr    = run && MemWrite && in_range;
    assign bad_acc  = run && (MemRead || MemWrite) && !in_range;

    always_comb begin
        state_d      = state_q;
        init_ptr_d   = init_ptr_q;
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        we           = 1'b0;
        waddr        = idx;
        wdata        = memWriteData;
        unique case (state_q)
            S_INIT: begin
                we         = 1'b1;
                waddr      = init_ptr_q;
                wdata      = INIT_VAL;
                init_ptr_d = init_ptr_q + 1'b1;
                if (init_ptr_q == AW'(DEPTH - 1)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                we = do_wr;
                if (bad_acc) begin
                    fault_d = 1'b1;
                    if (!fault_q) begin
                        fault_addr_d = memAddr;
                    end
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_INIT;
            init_ptr_q   <= '0;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            init_ptr_q   <= init_ptr_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    // Array is not reset; the init engine rewrites every word instead.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign memReadData = do_rd ? mem[idx] : 64'h0;
    assign ready       = run;
    assign fault       = fault_q;
    assign fault_addr  = fault_addr_q;

`ifdef DMEM_STATS_EN
    logic [31:0] rd_count_q, wr_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            if (do_rd && rd_count_q != 32'hFFFF_FFFF) begin
                rd_count_q <= rd_count_q + 32'd1;
            end
            if (do_wr && wr_count_q != 32'hFFFF_FFFF) begin
                wr_count_q <= wr_count_q + 32'd1;
            end
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: init timing, load/store, read-during-write,
// faults, reset during init, and counters when DMEM_STATS_EN is defined.
module tb_data_memory;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] memAddr;
    logic [63:0] memWriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [63:0] memReadData;
    logic        ready;
    logic        fault;
    logic [63:0] fault_addr;
`ifdef DMEM_STATS_EN
    logic [31:0] rd_count;
    logic [31:0] wr_count;
`endif

    int total = 0;
    int bad   = 0;

    data_memory #(
        .DEPTH(256),
        .AW(8),
        .INIT_VAL(64'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .memAddr(memAddr),
        .memWriteData(memWriteData),
        .MemWrite(MemWrite),
        .MemRead(MemRead),
        .memReadData(memReadData),
        .ready(ready),
        .fault(fault),
`ifdef DMEM_STATS_EN
        .rd_count(rd_count),
        .wr_count(wr_count),
`endif
        .fault_addr(fault_addr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        memAddr      = 64'h0;
        memWriteData = 64'h0;
    endtask

    // Counts edges from reset release until ready, bounded at 300.
    task automatic release_and_count(output int cyc);
        rst = 1'b0;
        cyc = 0;
        while (!ready && cyc < 300) begin
            step();
            cyc++;
        end
    endtask

    task automatic test_reset();
        int cyc;
        idle();
        rst = 1'b1;
        step();
        step();
        total++;
        if (ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready got=%b exp=0", ready);
        end
        total++;
        if (fault !== 1'b0 || fault_addr !== 64'h0) begin
            bad++;
            $display("FAIL reset_fault got=%b/%h exp=0/0", fault, fault_addr);
        end
        rst = 1'b0;
        // out-of-range traffic during init: no fault, read 0
        memAddr  = 64'd300;
        MemRead  = 1'b1;
        MemWrite = 1'b1;
        #1;
        total++;
        if (memReadData !== 64'h0) begin
            bad++;
            $display("FAIL init_read got=%h exp=0", memReadData);
        end
        step();
        step();
        total++;
        if (fault !== 1'b0) begin
            bad++;
            $display("FAIL init_nofault got=%b exp=0", fault);
        end
        idle();
        rst = 1'b1;
        step();
    endtask

    task automatic test_init();
        int cyc;
        rst = 1'b1;
        step();
        release_and_count(cyc);
        total++;
        if (cyc !== 256) begin
            bad++;
            $display("FAIL init_cycles got=%0d exp=256", cyc);
        end
        total++;
        if (ready !== 1'b1) begin
            bad++;
            $display("FAIL init_ready got=%b exp=1", ready);
        end
        memAddr = 64'd5;
        MemRead = 1'b1;
        #1;
        total++;
        if (memReadData !== 64'h0) begin
            bad++;
            $display("FAIL init_load5 got=%h exp=0", memReadData);
        end
        idle();
    endtask

    task automatic test_store_load();
        memAddr      = 64'd10;
        memWriteData = 64'hDEAD_BEEF_0123_4567;
        MemWrite     = 1'b1;
        step();
        MemWrite = 1'b0;
        MemRead  = 1'b1;
        #1;
        total++;
        if (memReadData !== 64'hDEAD_BEEF_0123_4567) begin
            bad++;
            $display("FAIL load10 got=%h exp=deadbeef01234567", memReadData);
        end
        memAddr = 64'd11;
        #1;
        total++;
        if (memReadData !== 64'h0) begin
            bad++;
            $display("FAIL load11 got=%h exp=0", memReadData);
        end
        memAddr = 64'd10;
        MemRead = 1'b0;
        #1;
        total++;
        if (memReadData !== 64'h0) begin
            bad++;
            $display("FAIL noread got=%h exp=0", memReadData);
        end
        memAddr      = 64'd255;
        memWriteData = 64'h0F0F_0000_1234_FFFF;
        MemWrite     = 1'b1;
        step();
        MemWrite = 1'b0;
        MemRead  = 1'b1;
        #1;
        total++;
        if (memReadData !== 64'h0F0F_0000_1234_FFFF) begin
            bad++;
            $display("FAIL load255 got=%h exp=0f0f00001234ffff", memReadData);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        memAddr      = 64'd3;
        memWriteData = 64'h1;
        MemWrite     = 1'b1;
        step();
        memWriteData = 64'h2;
        MemRead      = 1'b1;
        #1;
        total++;
        if (memReadData !== 64'h1) begin
            bad++;
            $display("FAIL rdw_old got=%h exp=1", memReadData);
        end
        step();
        MemWrite = 1'b0;
        #1;
        total++;
        if (memReadData !== 64'h2) begin
            bad++;
            $display("FAIL rdw_new got=%h exp=2", memReadData);
        end
        idle();
    endtask

    task automatic test_fault();
        #1;
        total++;
        if (fault !== 1'b0) begin
            bad++;
            $display("FAIL fault_pre got=%b exp=0", fault);
        end
        memAddr      = 64'd300;
        memWriteData = 64'h77;
        MemWrite     = 1'b1;
        step();
        MemWrite = 1'b0;
        total++;
        if (fault !== 1'b1 || fault_addr !== 64'd300) begin
            bad++;
            $display("FAIL fault_first got=%b/%0d exp=1/300", fault, fault_addr);
        end
        memAddr = 64'd512;
        MemRead = 1'b1;
        #1;
        total++;
        if (memReadData !== 64'h0) begin
            bad++;
            $display("FAIL fault_read512 got=%h exp=0", memReadData);
        end
        step();
        memAddr = 64'h8000_0000_0000_000A;
        #1;
        total++;
        if (memReadData !== 64'h0) begin
            bad++;
            $display("FAIL fault_alias10 got=%h exp=0", memReadData);
        end
        step();
        total++;
        if (fault !== 1'b1 || fault_addr !== 64'd300) begin
            bad++;
            $display("FAIL fault_sticky got=%b/%0d exp=1/300", fault, fault_addr);
        end
        memAddr = 64'd44;
        #1;
        total++;
        if (memReadData !== 64'h0) begin
            bad++;
            $display("FAIL fault_mem44 got=%h exp=0", memReadData);
        end
        idle();
    endtask

    task automatic test_reset_midinit();
        int cyc;
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (100) step();
        rst = 1'b1;
        #1;
        total++;
        if (ready !== 1'b0 || fault !== 1'b0) begin
            bad++;
            $display("FAIL midinit_rst got=%b/%b exp=0/0", ready, fault);
        end
        step();
        release_and_count(cyc);
        total++;
        if (cyc !== 256) begin
            bad++;
            $display("FAIL midinit_cycles got=%0d exp=256", cyc);
        end
        total++;
        if (fault !== 1'b0 || fault_addr !== 64'h0) begin
            bad++;
            $display("FAIL midinit_fault got=%b/%h exp=0/0", fault, fault_addr);
        end
        memAddr = 64'd10;
        MemRead = 1'b1;
        #1;
        total++;
        if (memReadData !== 64'h0) begin
            bad++;
            $display("FAIL midinit_cleared got=%h exp=0", memReadData);
        end
        idle();
    endtask

`ifdef DMEM_STATS_EN
    task automatic test_stats();
        total++;
        if (rd_count !== 32'd0 || wr_count !== 32'd0) begin
            bad++;
            $display("FAIL stats_reset got=%0d/%0d exp=0/0", rd_count, wr_count);
        end
        MemRead = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            memAddr = 64'(i);
            step();
        end
        MemRead  = 1'b0;
        MemWrite = 1'b1;
        for (int i = 4; i <= 5; i++) begin
            memAddr = 64'(i);
            step();
        end
        MemRead = 1'b1;
        memAddr = 64'd6;
        step();
        memAddr = 64'd1000;
        step();
        idle();
        step();
        total++;
        if (rd_count !== 32'd4 || wr_count !== 32'd3) begin
            bad++;
            $display("FAIL stats_count got=%0d/%0d exp=4/3", rd_count, wr_count);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_init();
        test_store_load();
        test_back_to_back();
        test_fault();
        test_reset_midinit();
`ifdef DMEM_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
